// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry and the write-arbiter state encoding.
package fb_pkg;

    localparam int FB_WIDTH      = 128;
    localparam int FB_HEIGHT     = 48;
    localparam int FB_SIZE       = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_WIDTH = 13;
    localparam int PIXEL_WIDTH   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester handshake bundle plus the RAM write port that the arbiter drives.
interface fb_write_arbiter_if
    import fb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH = PIXEL_WIDTH
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          wr_enable;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0]         wr_data;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_enable, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_enable, wr_addr, wr_data
    );

endinterface

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Round-robin picker: grants the first valid requester at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [2:0]         ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         winner
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW:0] NREQ = (IW+1)'(NUM_REQ);

    logic        found;
    logic [IW:0] pos;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr[IW-1:0]} + (IW+1)'(k);
            if (pos >= NREQ) pos = pos - NREQ;
            if (enable && !found && valid[pos[IW-1:0]]) begin
                found                = 1'b1;
                grant[pos[IW-1:0]]   = 1'b1;
                winner               = 3'(pos[IW-1:0]);
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the frame-buffer RAM write port between NUM_REQ pixel sources and a whole-buffer fill engine.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH = PIXEL_WIDTH,
    parameter int FB_SIZE    = FB_WIDTH * FB_HEIGHT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fb_write_arbiter_if.slave     bus,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic [2:0]            grant_id,
    output logic [15:0]           drop_count
);

    generate
        if (FB_SIZE > (1 << ADDR_WIDTH)) begin : g_size_check
            $error("FB_SIZE does not fit in ADDR_WIDTH address bits");
        end
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_req_check
            $error("NUM_REQ must be in 2..8");
        end
    endgenerate

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   SIZE_LIM  = (ADDR_WIDTH+1)'(FB_SIZE);
    localparam logic [2:0]            LAST_REQ  = 3'(NUM_REQ - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    arb_state_t            state, state_nxt;
    logic [2:0]            ptr, ptr_nxt;
    logic [ADDR_WIDTH-1:0] fill_cnt, fill_cnt_nxt;
    logic [DATA_WIDTH-1:0] fill_val, fill_val_nxt;
    logic                  wr_enable_p1, wr_enable_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr_p1, wr_addr_nxt;
    logic [DATA_WIDTH-1:0] wr_data_p1, wr_data_nxt;
    logic [2:0]            grant_id_nxt;
    logic [15:0]           drop_count_nxt;

    logic                  arb_en;
    logic [NUM_REQ-1:0]    grant;
    logic [2:0]            winner;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // A same-cycle fill_start wins over every requester, so arbitration is masked by it.
    assign arb_en = reset_n && (state == IDLE) && !fill_start;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .valid  (bus.req_valid),
        .ptr    (ptr),
        .enable (arb_en),
        .grant  (grant),
        .winner (winner)
    );

    assign bus.req_ready = grant;
    assign fill_busy     = (state == FILL);
    assign bus.wr_enable = wr_enable_p1;
    assign bus.wr_addr   = wr_addr_p1;
    assign bus.wr_data   = wr_data_p1;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = sel_data | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        fill_cnt_nxt   = fill_cnt;
        fill_val_nxt   = fill_val;
        wr_enable_nxt  = 1'b0;
        wr_addr_nxt    = wr_addr_p1;
        wr_data_nxt    = wr_data_p1;
        grant_id_nxt   = grant_id;
        drop_count_nxt = drop_count;
        case (state)
            IDLE: begin
                if (fill_start) begin
                    state_nxt    = FILL;
                    fill_val_nxt = fill_value;
                    fill_cnt_nxt = '0;
                end else if (|grant) begin
                    ptr_nxt      = (winner == LAST_REQ) ? 3'd0 : winner + 3'd1;
                    grant_id_nxt = winner;
                    if ({1'b0, sel_addr} < SIZE_LIM) begin
                        wr_enable_nxt = 1'b1;
                        wr_addr_nxt   = sel_addr;
                        wr_data_nxt   = sel_data;
                    end else begin
                        drop_count_nxt = sat_inc(drop_count);
                    end
                end
            end
            FILL: begin
                wr_enable_nxt = 1'b1;
                wr_addr_nxt   = fill_cnt;
                wr_data_nxt   = fill_val;
                if (fill_cnt == LAST_ADDR) state_nxt = IDLE;
                else fill_cnt_nxt = fill_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register stage p1: everything the RAM and debug ports see.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= '0;
            fill_cnt     <= '0;
            fill_val     <= '0;
            wr_enable_p1 <= 1'b0;
            wr_addr_p1   <= '0;
            wr_data_p1   <= '0;
            grant_id     <= '0;
            drop_count   <= '0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            fill_cnt     <= fill_cnt_nxt;
            fill_val     <= fill_val_nxt;
            wr_enable_p1 <= wr_enable_nxt;
            wr_addr_p1   <= wr_addr_nxt;
            wr_data_p1   <= wr_data_nxt;
            grant_id     <= grant_id_nxt;
            drop_count   <= drop_count_nxt;
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios and randomized traffic checked against a reference model.
module tb_fb_write_arbiter;
    import fb_pkg::*;

    localparam int N   = 3;
    localparam int AW  = FB_ADDR_WIDTH;
    localparam int DW  = PIXEL_WIDTH;
    localparam int FBS = FB_SIZE;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_value = '0;
    logic          fill_busy;
    logic [2:0]    grant_id;
    logic [15:0]   drop_count;

    fb_write_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fb_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FB_SIZE(FBS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .grant_id   (grant_id),
        .drop_count (drop_count)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic          v[8];
    logic [AW-1:0] a[8];
    logic [DW-1:0] d[8];

    // Reference model: pointer, fill progress and the expected registered outputs.
    int            m_ptr  = 0;
    bit            m_fill = 1'b0;
    int            m_done = 0;
    logic [DW-1:0] m_val  = '0;
    logic          e_wen  = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    logic [2:0]    e_gid  = '0;
    logic [15:0]   e_drop = '0;

    int            granted    = -1;
    logic [N-1:0]  last_ready = '0;
    logic          last_busy  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        logic [N-1:0]    rv;
        logic [N*AW-1:0] ra;
        logic [N*DW-1:0] rd;
        for (int i = 0; i < N; i++) begin
            rv[i]            = v[i];
            ra[i*AW +: AW]   = a[i];
            rd[i*DW +: DW]   = d[i];
        end
        bus.req_valid = rv;
        bus.req_addr  = ra;
        bus.req_data  = rd;
    endtask

    // One clock: check ready mid-cycle, advance the model at the edge, check registered outputs after it.
    task automatic step();
        int           win;
        logic [2:0]   idx;
        logic [N-1:0] er;
        apply();
        win = -1;
        if (reset_n && !m_fill && !fill_start) begin
            for (int k = 0; k < N; k++) begin
                idx = 3'((m_ptr + k) % N);
                if (win < 0 && v[idx]) win = int'(idx);
            end
        end
        er = (win >= 0) ? (N'(1) << win) : '0;
        @(negedge clk);
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        last_ready = bus.req_ready;
        last_busy  = fill_busy;
        @(posedge clk);
        if (!reset_n) begin
            m_ptr = 0; m_fill = 1'b0; e_wen = 1'b0; e_addr = '0; e_data = '0; e_gid = '0; e_drop = '0;
        end else if (m_fill) begin
            e_wen  = 1'b1;
            e_addr = AW'(m_done);
            e_data = m_val;
            m_done++;
            if (m_done == FBS) m_fill = 1'b0;
        end else if (fill_start) begin
            m_fill = 1'b1; m_done = 0; m_val = fill_value; e_wen = 1'b0;
        end else if (win >= 0) begin
            idx   = 3'(win);
            e_gid = idx;
            m_ptr = (win + 1) % N;
            if (int'(a[idx]) < FBS) begin
                e_wen = 1'b1; e_addr = a[idx]; e_data = d[idx];
            end else begin
                e_wen = 1'b0;
                if (e_drop != 16'hFFFF) e_drop++;
            end
        end else begin
            e_wen = 1'b0;
        end
        #1;
        chk("wr_enable", 32'(bus.wr_enable), 32'(e_wen));
        if (e_wen) begin
            chk("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
            chk("wr_data", 32'(bus.wr_data), 32'(e_data));
        end
        chk("grant_id", 32'(grant_id), 32'(e_gid));
        chk("drop_count", 32'(drop_count), 32'(e_drop));
        chk("fill_busy", 32'(fill_busy), 32'(m_fill));
        granted = win;
    endtask

    initial begin
        int            wen_cnt;
        int            busy_cycles, fill_writes, next_addr, order_err, ready_in_busy;
        bit            accepted, found;
        logic [AW-1:0] last_addr;

        for (int i = 0; i < 8; i++) begin
            v[i] = 1'b0; a[i] = '0; d[i] = '0;
        end

        // Reset state
        reset_n = 1'b0;
        step();
        step();
        chk("reset_wr_enable", 32'(bus.wr_enable), 0);
        chk("reset_wr_addr", 32'(bus.wr_addr), 0);
        chk("reset_wr_data", 32'(bus.wr_data), 0);
        chk("reset_ready", 32'(last_ready), 0);
        chk("reset_fill_busy", 32'(fill_busy), 0);
        chk("reset_grant_id", 32'(grant_id), 0);
        chk("reset_drop_count", 32'(drop_count), 0);
        reset_n = 1'b1;

        // Single requester
        v[1] = 1'b1; a[1] = 13'h0100; d[1] = 8'h5A;
        step();
        v[1] = 1'b0;
        chk("single_ready", 32'(last_ready), 32'b010);
        chk("single_wr_enable", 32'(bus.wr_enable), 1);
        chk("single_wr_addr", 32'(bus.wr_addr), 32'h0100);
        chk("single_wr_data", 32'(bus.wr_data), 32'h5A);
        chk("single_drop", 32'(drop_count), 0);
        step();
        chk("single_idle_after", 32'(bus.wr_enable), 0);

        // Fairness from ptr=0
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; a[i] = AW'(32'h10 + i); d[i] = DW'(32'hA0 + i);
        end
        wen_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("fair_grant", 32'(granted), 32'(k % 3));
            chk("fair_data", 32'(bus.wr_data), 32'hA0 + 32'(k % 3));
            chk("fair_addr", 32'(bus.wr_addr), 32'h10 + 32'(k % 3));
            if (bus.wr_enable) wen_cnt++;
        end
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        step();
        if (bus.wr_enable) wen_cnt++;
        chk("fair_write_count", 32'(wen_cnt), 9);

        // Randomized traffic, holding addr/data while valid and not yet accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(v[i] && granted != i)) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    a[i] = ($urandom_range(0, 7) == 0) ? AW'(FBS + $urandom_range(0, 2047))
                                                        : AW'($urandom_range(0, FBS - 1));
                    d[i] = DW'($urandom);
                end
            end
            step();
        end
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        step();

        // Full fill racing req2, with an ignored second fill_start mid-way
        v[2] = 1'b1; a[2] = 13'h0055; d[2] = 8'h77;
        fill_start = 1'b1; fill_value = 8'h00;
        step();
        fill_start = 1'b0;
        chk("fill_start_priority", 32'(last_ready), 0);
        busy_cycles = 0; fill_writes = 0; next_addr = 0; order_err = 0; ready_in_busy = 0; accepted = 1'b0;
        for (int k = 0; k < 6300 && !accepted; k++) begin
            fill_start = (k == 3000);
            fill_value = (k == 3000) ? 8'hFF : 8'h00;
            step();
            if (last_busy) begin
                busy_cycles++;
                if (last_ready[2]) ready_in_busy++;
                if (bus.wr_enable) begin
                    fill_writes++;
                    if (int'(bus.wr_addr) == next_addr && bus.wr_data == 8'h00) next_addr++;
                    else order_err++;
                end
            end else if (last_ready[2]) begin
                accepted = 1'b1;
            end
        end
        fill_start = 1'b0; fill_value = 8'h00;
        chk("fill_busy_cycles", 32'(busy_cycles), 6144);
        chk("fill_write_count", 32'(fill_writes), 6144);
        chk("fill_addr_coverage", 32'(next_addr), 6144);
        chk("fill_order_errors", 32'(order_err), 0);
        chk("fill_req2_blocked", 32'(ready_in_busy), 0);
        chk("fill_req2_accepted", 32'(accepted), 1);
        chk("fill_req2_wr_addr", 32'(bus.wr_addr), 32'h55);
        chk("fill_req2_wr_data", 32'(bus.wr_data), 32'h77);
        v[2] = 1'b0;
        step();

        // Reset during a fill after address 99 has been written
        fill_start = 1'b1; fill_value = 8'h3C;
        step();
        fill_start = 1'b0;
        found = 1'b0; last_addr = '0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            if (bus.wr_enable) last_addr = bus.wr_addr;
            if (bus.wr_enable && bus.wr_addr == 13'd99) found = 1'b1;
        end
        chk("reset_fill_reached_99", 32'(found), 1);
        reset_n = 1'b0;
        step();
        if (bus.wr_enable) last_addr = bus.wr_addr;
        chk("reset_fill_wr_enable", 32'(bus.wr_enable), 0);
        chk("reset_fill_busy", 32'(fill_busy), 0);
        chk("reset_fill_last_addr", 32'(last_addr), 99);
        reset_n = 1'b1;
        wen_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.wr_enable) wen_cnt++;
        end
        chk("reset_fill_no_writes", 32'(wen_cnt), 0);

        // Out-of-range drops and saturation
        v[0] = 1'b1; a[0] = 13'd6144; d[0] = 8'h11;
        step();
        chk("drop_ready", 32'(last_ready), 32'b001);
        chk("drop_no_write", 32'(bus.wr_enable), 0);
        chk("drop_first_count", 32'(drop_count), 1);
        wen_cnt = 0;
        for (int k = 1; k < 70000; k++) begin
            step();
            if (bus.wr_enable) wen_cnt++;
        end
        v[0] = 1'b0;
        chk("drop_saturated", 32'(drop_count), 32'hFFFF);
        chk("drop_never_wrote", 32'(wen_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single frame-buffer RAM write port between NUM_REQ independent pixel sources, e.g. the UART loader, the SPI display path and a pattern generator.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Includes a bulk fill engine that clears or paints the whole buffer.
- Sits between the pixel sources and the `ram` write port (wr_enable/wr_addr/wr_data); all requesters must already be in the `clk` domain.

Parameters:
- NUM_REQ, 3, number of requester ports (2..8).
- ADDR_WIDTH, 13, frame-buffer address width.
- DATA_WIDTH, 8, pixel width.
- FB_SIZE, 6144, number of valid frame-buffer locations (128*48).

Ports:
- clk  in  1  system clock (48 MHz)
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*DATA_WIDTH  packed pixel data, same packing
- fill_start  in  1  one-cycle pulse that starts a full-buffer fill
- fill_value  in  DATA_WIDTH  value written by the fill; sampled on fill_start
- fill_busy  out  1  high while a fill is in progress
- wr_enable  out  1  RAM write strobe
- wr_addr  out  ADDR_WIDTH  RAM write address
- wr_data  out  DATA_WIDTH  RAM write data
- grant_id  out  3  index of the last accepted requester (debug)
- drop_count  out  16  saturating count of out-of-range requests

Behaviour:
- Reset (reset_n=0 at a clk edge) forces:
  - wr_enable=0, wr_addr=0, wr_data=0;
  - req_ready=0, fill_busy=0, grant_id=0, drop_count=0;
  - rr pointer=0, state=IDLE.
- Reset mid-fill aborts the fill immediately; no further writes occur.
- Transfer rule: a transfer occurs on a cycle where req_valid[i] && req_ready[i]. Requesters hold addr/data stable while valid and not ready.
- req_ready is combinational from req_valid, the rr pointer and the state. It is all-zero in FILL state and during reset.
- Arbitration (IDLE state):
  - Scan starts at index ptr and wraps modulo NUM_REQ; the first valid index wins.
  - After a grant to i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr is unchanged.
  - Throughput is one write per cycle. A requester holding valid high continuously is served at least once every NUM_REQ cycles.
- Write latency: an accepted transfer at cycle N gives wr_enable=1 with the registered addr/data at cycle N+1. Outputs are registered; wr_enable=0 otherwise.
- Range check:
  - If the accepted addr >= FB_SIZE, the request is still accepted (ready=1) but wr_enable stays 0.
  - drop_count increments and saturates at 16'hFFFF.
- grant_id updates on every accepted transfer, including dropped ones.
- States: IDLE, FILL.
  - IDLE -> FILL on fill_start=1. This takes priority over any same-cycle request: no ready is issued that cycle. fill_value is latched and fill counter=0.
  - FILL:
    - fill_busy=1.
    - Each cycle writes wr_addr=counter, wr_data=latched value, wr_enable=1.
    - Addresses 0..FB_SIZE-1 are each written exactly once, in order, over exactly FB_SIZE consecutive cycles.
    - fill_start is ignored while in FILL.
  - FILL -> IDLE after the cycle that writes FB_SIZE-1. fill_busy drops the following cycle, and requests may be accepted in that same cycle.
- Arithmetic:
  - The fill counter is ADDR_WIDTH bits and never exceeds FB_SIZE-1.
  - The pointer is 3 bits, compared modulo NUM_REQ.
  - FB_SIZE must be <= 2^ADDR_WIDTH; the design gives an elaboration error otherwise.

Decomposition:
- Shared package fb_pkg holds:
  - FB_WIDTH=128, FB_HEIGHT=48, FB_SIZE=6144, FB_ADDR_WIDTH=13, PIXEL_WIDTH=8;
  - state encodings IDLE=0, FILL=1.
- Sub-module rr_arbiter (NUM_REQ) is a natural split:
  - inputs: valid vector, ptr, enable;
  - outputs: one-hot grant and winner index.
- The fill engine and output registers live in the top.

Test Plan:
- Single requester: req1 sends addr=0x0100, data=0x5A, valid held one cycle -> ready1=1 same cycle; next cycle wr_enable=1, wr_addr=0x0100, wr_data=0x5A; drop_count=0.
- Fairness: all three requesters hold valid for 9 cycles from ptr=0 -> grants in order 0,1,2,0,1,2,0,1,2; exactly 9 writes; each RAM write carries the granted requester's data.
- Out of range: req0 sends addr=6144 -> ready0=1, no wr_enable, drop_count=1. Repeat 70000 times -> drop_count saturates at 0xFFFF.
- Fill: fill_start with fill_value=0x00 while req2 is valid -> req2 is not ready for 6144 cycles; writes cover 0..6143 in order with data 0x00; fill_busy high for exactly 6144 cycles; req2 is accepted the cycle fill_busy falls.
- Fill contention: a second fill_start mid-fill is ignored, so total writes = 6144. Asserting reset_n=0 at fill cycle 100 -> next cycle wr_enable=0, fill_busy=0, and the last written address was 99.
